// File: rtl/ex_stage_pipelined.sv
// Registered, handshaked execute stage: single-cycle ALU ops with NZCV flags,
// an iterative shift-add multiplier, and a latched branch target.
module ex_stage_pipelined #(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] pc_in_i,
    input  logic [WIDTH-1:0] read_data1_i,
    input  logic [WIDTH-1:0] read_data2_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic             alu_src_i,
    input  logic [3:0]       alu_ctl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_result_o,
    output logic [3:0]       flags_o,
    output logic [WIDTH-1:0] branch_target_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] bt_q, bt_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_mul;
    logic [WIDTH-1:0] acc_step;
    logic             mul_last;
    logic             accept;

    // Single-cycle ALU; SUB is A + ~B + 1 so carry-out means "no borrow".
    always_comb begin
        op_b    = alu_src_i ? imm_i : read_data2_i;
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_mul = 1'b0;
        case (alu_ctl_i)
            OP_AND:  alu_res = read_data1_i & op_b;
            OP_ORR:  alu_res = read_data1_i | op_b;
            OP_ADD: begin
                sum     = {1'b0, read_data1_i} + {1'b0, op_b};
                alu_res = sum[M:0];
                alu_c   = sum[WIDTH];
                alu_v   = (read_data1_i[M] == op_b[M]) && (sum[M] != read_data1_i[M]);
            end
            OP_SUB: begin
                sum     = {1'b0, read_data1_i} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum[M:0];
                alu_c   = sum[WIDTH];
                alu_v   = (read_data1_i[M] != op_b[M]) && (sum[M] != read_data1_i[M]);
            end
            OP_PASS: alu_res = op_b;
            OP_NOR:  alu_res = ~(read_data1_i | op_b);
            OP_MUL:  alu_mul = MUL_EN;
            default: alu_res = '0;
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (cnt_q == CW'(WIDTH - 1));
    assign accept   = in_valid_i && in_ready_o;

    // FSM: state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && alu_mul) state_d = S_MUL;
            S_MUL:  if (mul_last)          state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready_o = (state_q == S_IDLE) && (!ov_q || out_ready_i);
        busy_o     = (state_q == S_MUL);
    end

    // Datapath next-state; a result write on the consuming edge keeps out_valid high.
    always_comb begin
        res_d    = res_q;
        flags_d  = flags_q;
        bt_d     = bt_q;
        ov_d     = ov_q && !out_ready_i;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    bt_d = pc_in_i + (imm_i << 2);
                    if (alu_mul) begin
                        mcand_d  = op_b;
                        mplier_d = read_data1_i;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        res_d   = alu_res;
                        flags_d = {alu_res[M], ~|alu_res, alu_c, alu_v};
                        ov_d    = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (mul_last) begin
                    res_d   = acc_step;
                    flags_d = {acc_step[M], ~|acc_step, 2'b00};
                    ov_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            res_q    <= '0;
            flags_q  <= '0;
            bt_q     <= '0;
            ov_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            res_q    <= res_d;
            flags_q  <= flags_d;
            bt_q     <= bt_d;
            ov_q     <= ov_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid_o     = ov_q;
    assign alu_result_o    = res_q;
    assign flags_o         = flags_q;
    assign branch_target_o = bt_q;

endmodule

// File: tb/tb_ex_stage_pipelined.sv
// Bench for ex_stage_pipelined: three instances (64-bit, 8-bit with MUL, 8-bit
// without MUL) checked against an arithmetic model plus literal expectations.
module tb_ex_stage_pipelined;

    localparam logic [3:0] AND_ = 4'b0000, ADD = 4'b0010, SUB = 4'b0110, PASSB = 4'b0111;
    localparam logic [3:0] NOR_ = 4'b1100, MUL = 4'b1000, BAD = 4'b0011;

    int WID [3] = '{64, 8, 8};
    bit MEN [3] = '{1'b1, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0] d_pc, d_a, d_b, d_imm;
    logic        d_src;
    logic [3:0]  d_ctl;
    logic [2:0]  iv, ordy, ir, ov, bz;
    logic [2:0][3:0]  flg;
    logic [2:0][63:0] resv, btv;

    int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
    logic [131:0] q [3][$];
    logic [63:0]  log0 [$];

    always @(posedge clk) cyc <= cyc + 1;

    assign resv[1][63:8] = '0;
    assign resv[2][63:8] = '0;
    assign btv[1][63:8]  = '0;
    assign btv[2][63:8]  = '0;

    ex_stage_pipelined #(.WIDTH(64), .MUL_EN(1'b1)) u64 (
        .clk_i(clk), .reset_i(rst), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
        .pc_in_i(d_pc), .read_data1_i(d_a), .read_data2_i(d_b), .imm_i(d_imm),
        .alu_src_i(d_src), .alu_ctl_i(d_ctl), .out_valid_o(ov[0]), .out_ready_i(ordy[0]),
        .alu_result_o(resv[0]), .flags_o(flg[0]), .branch_target_o(btv[0]), .busy_o(bz[0]));

    ex_stage_pipelined #(.WIDTH(8), .MUL_EN(1'b1)) u8m (
        .clk_i(clk), .reset_i(rst), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
        .pc_in_i(d_pc[7:0]), .read_data1_i(d_a[7:0]), .read_data2_i(d_b[7:0]), .imm_i(d_imm[7:0]),
        .alu_src_i(d_src), .alu_ctl_i(d_ctl), .out_valid_o(ov[1]), .out_ready_i(ordy[1]),
        .alu_result_o(resv[1][7:0]), .flags_o(flg[1]), .branch_target_o(btv[1][7:0]), .busy_o(bz[1]));

    ex_stage_pipelined #(.WIDTH(8), .MUL_EN(1'b0)) u8n (
        .clk_i(clk), .reset_i(rst), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
        .pc_in_i(d_pc[7:0]), .read_data1_i(d_a[7:0]), .read_data2_i(d_b[7:0]), .imm_i(d_imm[7:0]),
        .alu_src_i(d_src), .alu_ctl_i(d_ctl), .out_valid_o(ov[2]), .out_ready_i(ordy[2]),
        .alu_result_o(resv[2][7:0]), .flags_o(flg[2]), .branch_target_o(btv[2][7:0]), .busy_o(bz[2]));

    // Signed value of the low w bits, as a wide integer.
    function automatic logic signed [129:0] sx(logic [127:0] x, int w);
        logic signed [129:0] r;
        r = $signed({2'b00, x});
        if (x[w-1]) r = r - (130'sd1 <<< w);
        return r;
    endfunction

    function automatic logic ovf(logic signed [129:0] x, int w);
        logic signed [129:0] lim;
        lim = 130'sd1 <<< (w - 1);
        return (x >= lim) || (x < -lim);
    endfunction

    // Returns {result[63:0], N, Z, C, V, branch_target[63:0]}.
    function automatic logic [131:0] model(int w, bit men, logic [63:0] pc, logic [63:0] a,
                                           logic [63:0] rb, logic [63:0] im, logic src,
                                           logic [3:0] ctl);
        logic [127:0] mask, ua, ub, res, full, bt;
        logic c, v;
        mask = (128'd1 << w) - 128'd1;
        ua   = {64'd0, a} & mask;
        ub   = {64'd0, (src ? im : rb)} & mask;
        c = 1'b0; v = 1'b0; res = '0; full = '0;
        case (ctl)
            4'b0000: res = ua & ub;
            4'b0001: res = ua | ub;
            4'b0010: begin
                full = ua + ub;
                res  = full & mask;
                c    = (full >> w) != 0;
                v    = ovf(sx(ua, w) + sx(ub, w), w);
            end
            4'b0110: begin
                res = (ua - ub) & mask;
                c   = (ua >= ub);
                v   = ovf(sx(ua, w) - sx(ub, w), w);
            end
            4'b0111: res = ub;
            4'b1100: res = ~(ua | ub) & mask;
            4'b1000: res = men ? ((ua * ub) & mask) : '0;
            default: res = '0;
        endcase
        bt = ({64'd0, pc} + ({64'd0, im} << 2)) & mask;
        return {res[63:0], res[w-1], (res == 0), c, v, bt[63:0]};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(int i, logic [3:0] ctl, logic [63:0] a, logic [63:0] b,
                         logic [63:0] im, logic src, logic [63:0] pc);
        bit ok;
        ok = 1'b0;
        d_ctl = ctl; d_a = a; d_b = b; d_imm = im; d_src = src; d_pc = pc;
        iv[i] = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = ir[i];
            @(posedge clk);
            #1;
        end
        iv[i] = 1'b0;
        acc_cyc = cyc;
        if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_out(int i, output logic [63:0] r, output logic [3:0] f,
                            output logic [63:0] bt, output int lat);
        bit seen;
        seen = 1'b0; r = 'x; f = 'x; bt = 'x; lat = -1;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (ov[i]) begin
                seen = 1'b1; r = resv[i]; f = flg[i]; bt = btv[i]; lat = cyc - acc_cyc;
            end
        end
        if (!seen) chk("result_timeout", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
    endtask

    logic [63:0] r, bt;
    logic [3:0]  f;
    int          lat;

    initial begin
        rst = 1'b1; iv = '0; ordy = '1;
        d_pc = '0; d_a = '0; d_b = '0; d_imm = '0; d_src = 1'b0; d_ctl = '0;

        // Model comparison on every cycle a result is presented.
        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    for (int i = 0; i < 3; i++) q[i].delete();
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (ov[i]) begin
                            checks++;
                            if (q[i].size() == 0) begin
                                errors++;
                                $display("FAIL unexpected_result inst=%0d got res=%h", i, resv[i]);
                            end else begin
                                if ({resv[i], flg[i], btv[i]} !== q[i][0]) begin
                                    errors++;
                                    $display("FAIL model inst=%0d got res=%h nzcv=%b bt=%h expected res=%h nzcv=%b bt=%h",
                                             i, resv[i], flg[i], btv[i], q[i][0][131:68], q[i][0][67:64], q[i][0][63:0]);
                                end
                                if (ordy[i]) begin
                                    if (i == 0) log0.push_back(resv[0]);
                                    void'(q[i].pop_front());
                                end
                            end
                        end
                        if (iv[i] && ir[i])
                            q[i].push_back(model(WID[i], MEN[i], d_pc, d_a, d_b, d_imm, d_src, d_ctl));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", 64'(ov[i]), 64'd0);
            chk("rst_busy", 64'(bz[i]), 64'd0);
            chk("rst_result", resv[i], 64'd0);
            chk("rst_flags", 64'(flg[i]), 64'd0);
            chk("rst_bt", btv[i], 64'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("rst_in_ready", 64'(ir[i]), 64'd1);
        @(posedge clk); #1;

        issue(0, ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 64'd0);
        wait_out(0, r, f, bt, lat);
        chk("add_ovf_res", r, 64'h8000_0000_0000_0000);
        chk("add_ovf_flags", 64'(f), 64'b1001);
        chk("single_latency", 64'(lat), 64'd0);

        issue(0, SUB, 64'd5, 64'd5, 64'd0, 1'b0, 64'd0);
        wait_out(0, r, f, bt, lat);
        chk("sub_eq_res", r, 64'd0);
        chk("sub_eq_flags", 64'(f), 64'b0110);

        issue(0, SUB, 64'd3, 64'd5, 64'd0, 1'b0, 64'd0);
        wait_out(0, r, f, bt, lat);
        chk("sub_neg_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_neg_flags", 64'(f), 64'b1000);

        issue(0, PASSB, 64'd0, 64'd9, 64'd2, 1'b1, 64'h100);
        wait_out(0, r, f, bt, lat);
        chk("passb_imm_res", r, 64'd2);
        chk("branch_target", bt, 64'h108);

        issue(0, NOR_, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0);
        wait_out(0, r, f, bt, lat);
        chk("nor_res", r, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("nor_flags", 64'(f), 64'b1000);

        issue(0, BAD, 64'd6, 64'd7, 64'd0, 1'b0, 64'd0);
        wait_out(0, r, f, bt, lat);
        chk("bad_op_res", r, 64'd0);
        chk("bad_op_flags", 64'(f), 64'b0100);

        issue(0, AND_, 64'hF0F0, 64'h0FF0, 64'd0, 1'b0, 64'd4);
        wait_out(0, r, f, bt, lat);
        chk("and_res", r, 64'h00F0);

        issue(2, ADD, 64'hFF, 64'd1, 64'd0, 1'b0, 64'd0);
        wait_out(2, r, f, bt, lat);
        chk("add8_wrap_res", r, 64'd0);
        chk("add8_wrap_flags", 64'(f), 64'b0110);

        issue(2, SUB, 64'h80, 64'd1, 64'd0, 1'b0, 64'd0);
        wait_out(2, r, f, bt, lat);
        chk("sub8_ovf_res", r, 64'h7F);
        chk("sub8_ovf_flags", 64'(f), 64'b0011);

        issue(2, MUL, 64'd6, 64'd7, 64'd0, 1'b0, 64'd0);
        wait_out(2, r, f, bt, lat);
        chk("mul_dis_res", r, 64'd0);
        chk("mul_dis_flags", 64'(f), 64'b0100);
        chk("mul_dis_latency", 64'(lat), 64'd0);

        issue(1, MUL, 64'd13, 64'd11, 64'd0, 1'b0, 64'd0);
        @(negedge clk);
        chk("mul_busy", 64'(bz[1]), 64'd1);
        chk("mul_in_ready", 64'(ir[1]), 64'd0);
        @(posedge clk); #1;
        wait_out(1, r, f, bt, lat);
        chk("mul8_res", r, 64'h8F);
        chk("mul8_flags", 64'(f), 64'b1000);
        chk("mul8_latency", 64'(lat), 64'd8);

        issue(1, MUL, 64'hFF, 64'hFF, 64'd0, 1'b0, 64'd0);
        wait_out(1, r, f, bt, lat);
        chk("mul8_ff_res", r, 64'h01);
        chk("mul8_ff_flags", 64'(f), 64'b0000);

        // Backpressure: results must come out 1..4 in order across a 3-cycle stall.
        log0.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) issue(0, ADD, 64'(k), 64'd1, 64'd0, 1'b0, 64'd0);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int n = 0; n < 50 && !seen; n++) begin
                    @(negedge clk);
                    seen = ov[0];
                end
                chk("bp_first_result", 64'(seen), 64'd1);
                @(posedge clk); #1 ordy[0] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_stall_in_ready", 64'(ir[0]), 64'd0);
                    chk("bp_stall_out_valid", 64'(ov[0]), 64'd1);
                    @(posedge clk); #1;
                end
                ordy[0] = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", 64'(log0.size()), 64'd4);
        for (int k = 0; k < 4 && k < log0.size(); k++) chk("bp_order", log0[k], 64'(k + 1));

        issue(0, MUL, 64'd3, 64'd5, 64'd0, 1'b0, 64'd0);
        @(negedge clk);
        chk("mul64_busy", 64'(bz[0]), 64'd1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 64'(ov[0]), 64'd0);
        chk("abort_busy", 64'(bz[0]), 64'd0);
        chk("abort_result", resv[0], 64'd0);
        chk("abort_flags", 64'(flg[0]), 64'd0);
        chk("abort_bt", btv[0], 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        issue(0, ADD, 64'd3, 64'd4, 64'd0, 1'b0, 64'd0);
        wait_out(0, r, f, bt, lat);
        chk("post_abort_add", r, 64'd7);

        repeat (80) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("drained", 64'(q[i].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage_pipelined.md
# ex_stage_pipelined

Parametrised, handshaked execute stage for the ARMv8/LEGv8 datapath. It generalises the combinational execute stage into a registered unit with a configurable datapath width, NZCV flag generation, and an iterative multi-cycle multiplier. It sits between the ID/EX pipeline register and the memory stage. It accepts one operation per valid/ready handshake and presents a registered result, flags and branch target downstream.

## Interface
- WIDTH, 64: datapath width in bits (≥ 8).
- MUL_EN, 1: 1 enables the iterative MUL op; 0 makes MUL an unsupported op.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  an operation is offered.
- in_ready  out  1  the stage can accept an operation this cycle.
- pc_in  in  WIDTH  PC of the instruction.
- read_data1  in  WIDTH  operand A.
- read_data2  in  WIDTH  register operand B.
- imm  in  WIDTH  sign-extended immediate / branch offset.
- alu_src  in  1  0: B = read_data2; 1: B = imm.
- alu_ctl  in  4  operation code (see Operation).
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  downstream consumes the result this cycle.
- alu_result  out  WIDTH  registered result.
- flags  out  4  registered {N,Z,C,V}.
- branch_target  out  WIDTH  registered pc_in + (imm << 2), truncated to WIDTH.
- busy  out  1  a MUL is in progress.

## Operation
- Operation codes (alu_ctl):
  - 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB (A − B), 0111 PASSB, 1100 NOR.
  - 1000 MUL: low WIDTH bits of A×B, unsigned.
  - Any other code, and MUL when MUL_EN=0: result 0, flags {0,1,0,0}, single-cycle.
- Accept:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on a rising edge where in_valid && in_ready.
  - Operands, alu_src selection and branch target are captured at accept. Inputs are don't-care afterwards.
- States:
  - IDLE: single-cycle ops write alu_result, flags, branch_target and set out_valid at the accepting edge. An accepted MUL loads multiplicand = B, multiplier = A, acc = 0, count = 0, latches branch_target, and goes to MUL.
  - MUL: each edge, if multiplier[0] then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++. On the edge where count reaches WIDTH−1 (WIDTH iterations total), write alu_result = final acc and flags, set out_valid, and return to IDLE.
  - busy = (state==MUL).
- Output:
  - out_valid clears on an edge with out_valid && out_ready, unless a new result is written on that same edge, in which case it stays 1.
  - Outputs stay stable while out_valid && !out_ready.
- Flags, all computed in WIDTH bits:
  - N = result[WIDTH−1]; Z = (result==0).
  - ADD: C = carry-out of A+B; V = signed overflow.
  - SUB: computed as A + ~B + 1. C = carry-out (1 = no borrow); V = signed overflow.
  - All other ops: C = V = 0.
- Reset (any time, including mid-MUL):
  - State returns to IDLE and any MUL in progress is aborted and discarded.
  - out_valid=0, busy=0, alu_result=0, flags=0000, branch_target=0.
  - in_ready=1 after reset is released.

## Timing
- Single-cycle op: accepted at edge k, result valid after edge k. Throughput is 1/cycle with out_ready held high.
- MUL: accepted at edge k; out_valid rises after edge k+WIDTH. in_ready is 0 from after edge k until after edge k+WIDTH. Throughput is 1 per WIDTH+1 cycles.
- Back-to-back: with out_valid=1 and out_ready=1, a new op is accepted in the same cycle. The output registers are overwritten and out_valid stays 1.
- Stall: out_valid=1, out_ready=0 → in_ready=0, and no input is consumed.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready.

## Test plan
- Reset mid-MUL: WIDTH=64, start a MUL, assert reset 10 cycles in → next cycle out_valid=0, busy=0, all outputs 0; after release the next ADD 3+4 yields 7.
- ADD/SUB flags: ADD 0x7FFF…FFFF + 1 → result 0x8000…0000, flags 1001. SUB 5−5 → result 0, flags 0110. SUB 3−5 → result 0xFFFF…FFFE, flags 1000.
- alu_src and branch target: read_data2=9, imm=2, alu_src=1, PASSB, pc_in=0x100 → result 2, branch_target 0x108.
- MUL latency (WIDTH=8): 13×11 → alu_result 0x8F, out_valid exactly 8 cycles after accept. 0xFF×0xFF → 0x01, flags 0000.
- Backpressure: stream 4 ADDs with out_ready low for 3 cycles after the first result → no ops lost or reordered, in_ready=0 during the stall, results 1,2,3,4 in order.
- Unsupported op (MUL_EN=0): alu_ctl=1000 with A=6, B=7 → result 0, flags 0100, single-cycle.
